fetch_decode_ctrl: RTL
======================

Name: fetch_decode_ctrl

Overview:
- Multi-cycle fetch/decode/sequencing control stage that sits directly upstream of the register-file/ALU datapath step.
- Owns the PC and the instruction register, and fetches 16-bit instructions over a req/ack memory handshake.
- Decodes each instruction into the datapath control fields (ALUOp, ALUSrcA/B, immediate, register addresses).
- Sequences the datapath through its two-cycle operand latency, then captures the ALU result and drives register-file writeback.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
R0_ZERO, 1, when 1, writes to rd=0 are suppressed (writeEnable held 0).

Ports:
CLK  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
imem_req  output  1  instruction fetch request.
imem_addr  output  16  fetch address; always equals PC.
imem_ack  input  1  memory has imem_data valid this cycle.
imem_data  input  16  fetched instruction.
ALUOut  input  16  signed ALU result from the datapath.
PC  output  16  current program counter.
ALUOp  output  3  ALU operation.
immediate  output  16  signed, sign-extended immediate.
ALUSrcA  output  1  0 selects PC, 1 selects register A.
ALUSrcB  output  1  0 selects register B, 1 selects immediate.
rdAddr  output  4  destination register.
rs0Addr  output  4  source register 0.
rs1Addr  output  4  source register 1.
writeEnable  output  1  register-file write strobe.
dataWrite  output  16  register-file write data.
halted  output  1  core halted.

Behaviour:
- Instruction encoding:
  - [15:12] opcode, [11:8] rd, [7:4] rs0, [3:0] rs1/imm4.
  - opcode[3]=0: R-type. ALUOp=opcode[2:0], ALUSrcA=1, ALUSrcB=0.
  - opcode 1000-1110: I-type. ALUOp=opcode[2:0], ALUSrcA=1, ALUSrcB=1, immediate = sign-extend(imm4), so 4'hF gives 16'hFFFF.
  - opcode 1111: HALT.
- State machine: FETCH -> DECODE -> EXEC1 -> EXEC2 -> WB -> FETCH. HALT is absorbing.
- FETCH:
  - imem_req=1 and imem_addr=PC.
  - Stays in FETCH until imem_ack=1. On the ack edge, IR <= imem_data and the next state is DECODE.
  - Unbounded wait; no timeout.
- DECODE: rs0Addr/rs1Addr/rdAddr, ALUOp, ALUSrcA/B and immediate are driven from IR. These fields are combinational from IR and stay stable until the next fetch completes. The datapath A/B registers latch at the end of DECODE.
- EXEC1: the datapath ALU input muxes latch at the end of EXEC1.
- EXEC2: result register <= ALUOut at the end of EXEC2.
- WB:
  - writeEnable=1 for exactly one cycle; dataWrite = result register.
  - writeEnable is forced to 0 if R0_ZERO=1 and rd=0.
  - PC <= PC+1 at the end of WB. PC wraps 16'hFFFF -> 16'h0000.
- HALT:
  - Entered from DECODE when opcode=1111.
  - In HALT: halted=1, imem_req=0, writeEnable=0, PC frozen.
  - Left only via reset.
- Latency: 5 cycles per instruction with zero-wait memory (ack in the first FETCH cycle).
- imem_req and writeEnable are 0 whenever reset=1, even combinationally.
- imem_ack outside FETCH is ignored.
- Reset values:
  - state=FETCH, PC=RESET_PC, IR=16'h0000 (so all decoded outputs are 0), result register=0.
  - writeEnable=0, dataWrite=0, halted=0.
  - imem_req rises in the first cycle after reset deasserts.
- Reset mid-operation: any state returns to FETCH on the next edge. A pending WB write is cancelled and PC is not incremented.
- imem_data is sampled only on the ack edge; later changes to imem_data have no effect.

Test Plan:
- Reset, then instruction 16'h0312 (R-type, ALUOp=0, rd=3, rs0=1, rs1=2) with ack in the same cycle -> ALUSrcA=1, ALUSrcB=0, rs0Addr=1, rs1Addr=2; ALUOut=16'h0007 in EXEC2 gives writeEnable=1, rdAddr=3, dataWrite=16'h0007 exactly 4 cycles after the ack edge; PC goes 0 -> 1.
- Instruction 16'h924F (I-type, ALUOp=1, rd=2, rs0=4, imm=F) -> immediate=16'hFFFF, ALUSrcB=1.
- imem_ack held low 3 cycles -> imem_req stays 1, imem_addr stable, state stays FETCH; ack on the 4th cycle proceeds normally.
- Instruction 16'h0012 with R0_ZERO=1 -> writeEnable stays 0 in WB; PC still increments.
- RESET_PC=16'hFFFF with one instruction -> PC=16'h0000 after WB.
- Instruction 16'hF000 -> halted=1 and imem_req=0 indefinitely. Reset pulsed in EXEC2 of a separate instruction -> no write, PC=RESET_PC, imem_req=1 one cycle after reset falls.

Source files
------------

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl
//   Multi-cycle control stage in front of the register-file/ALU datapath.
//   It owns the PC and the instruction register (IR). It fetches 16-bit
//   instructions over a req/ack handshake and decodes them into datapath
//   control fields. It then waits out the two-cycle operand latency,
//   captures the ALU result and drives one register-file write.
//
//   Sequence: FETCH -> DECODE -> EXEC1 -> EXEC2 -> WB -> FETCH.
//   HALT is absorbing and is left only through reset.
//
// Ports
//   CLK          clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   imem_req     instruction fetch request (FETCH only, 0 while reset=1)
//   imem_addr    fetch address, always equal to PC
//   imem_ack     imem_data is valid this cycle (ignored outside FETCH)
//   imem_data    fetched instruction
//   ALUOut       ALU result from the datapath, captured at the end of EXEC2
//   PC           current program counter
//   ALUOp        ALU operation
//   immediate    sign-extended 4-bit immediate (I-type)
//   ALUSrcA      0 = PC, 1 = register A
//   ALUSrcB      0 = register B, 1 = immediate
//   rdAddr       destination register
//   rs0Addr      source register 0
//   rs1Addr      source register 1
//   writeEnable  register-file write strobe (WB only)
//   dataWrite    register-file write data (result register)
//   halted       core is halted
module fetch_decode_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter bit          R0_ZERO  = 1'b1
) (
   input  logic        CLK,
   input  logic        reset,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   input  logic [15:0] ALUOut,
   output logic [15:0] PC,
   output logic [2:0]  ALUOp,
   output logic [15:0] immediate,
   output logic        ALUSrcA,
   output logic        ALUSrcB,
   output logic [3:0]  rdAddr,
   output logic [3:0]  rs0Addr,
   output logic [3:0]  rs1Addr,
   output logic        writeEnable,
   output logic [15:0] dataWrite,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC1  = 3'd2,
      S_EXEC2  = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   // Marks that IR holds a fetched instruction. Without it, IR=0 after
   // reset would decode as an R-type and drive ALUSrcA=1.
   logic        ir_valid_q, ir_valid_d;
   logic [15:0] result_q, result_d;
   logic [3:0]  opcode_s;

   assign opcode_s = ir_q[15:12];

   // State register and datapath-side registers.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         ir_q       <= 16'h0000;
         ir_valid_q <= 1'b0;
         result_q   <= 16'h0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         result_q   <= result_d;
      end
   end

   // Next-state logic for the sequencer, PC, IR and result register.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      result_d   = result_q;
      case (state_q)
         S_FETCH: begin
            // imem_data is sampled only on the ack edge.
            if (imem_ack) begin
               ir_d       = imem_data;
               ir_valid_d = 1'b1;
               state_d    = S_DECODE;
            end else begin
               state_d    = S_FETCH;
            end
         end
         S_DECODE: begin
            if (opcode_s == 4'hF) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC1;
            end
         end
         S_EXEC1: state_d = S_EXEC2;
         S_EXEC2: begin
            result_d = ALUOut;
            state_d  = S_WB;
         end
         S_WB: begin
            pc_d    = pc_q + 16'd1;   // wraps FFFF -> 0000
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Instruction decode; fields follow IR and hold until the next fetch.
   always_comb begin
      ALUOp     = 3'd0;
      immediate = 16'h0000;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      if (ir_valid_q) begin
         if (opcode_s[3] == 1'b0) begin
            ALUOp   = opcode_s[2:0];
            ALUSrcA = 1'b1;
            ALUSrcB = 1'b0;
         end else if (opcode_s != 4'hF) begin
            ALUOp     = opcode_s[2:0];
            ALUSrcA   = 1'b1;
            ALUSrcB   = 1'b1;
            immediate = {{12{ir_q[3]}}, ir_q[3:0]};
         end else begin
            // HALT drives no ALU control.
            ALUOp   = 3'd0;
            ALUSrcA = 1'b0;
            ALUSrcB = 1'b0;
         end
      end else begin
         ALUOp   = 3'd0;
         ALUSrcA = 1'b0;
         ALUSrcB = 1'b0;
      end
   end

   assign rdAddr    = ir_q[11:8];
   assign rs0Addr   = ir_q[7:4];
   assign rs1Addr   = ir_q[3:0];
   assign PC        = pc_q;
   assign imem_addr = pc_q;
   assign dataWrite = result_q;
   assign halted    = (state_q == S_HALT);

   // The strobes are gated by reset directly so that they drop in the same
   // cycle reset rises, not one edge later.
   assign imem_req    = (state_q == S_FETCH) && !reset;
   assign writeEnable = (state_q == S_WB) && !reset &&
                        !((R0_ZERO == 1'b1) && (ir_q[11:8] == 4'd0));

endmodule
